// File: rtl/ladder_serial_tx.sv
// ladder_serial_tx
//   Frame serializer on the ladder card. Parallel words from ladder logic are
//   accepted over a valid/ready handshake and shifted out LSB first on an
//   idle-high serial line toward the RDO board. The frame is a start bit (0),
//   DATA_W data bits, an optional even-parity bit and a stop bit (1). Every
//   bit is held for CLKS_PER_BIT clock cycles.
//
//   TX_OUT comes straight from a flop, so the pad-side GLOBAL/LCELL buffer
//   sees a glitch-free line.
//
//   Build option:
//     LADDER_TX_PARITY_EN  when defined, an even-parity bit (the XOR of the
//                          latched word) is sent between the last data bit
//                          and the stop bit.
//
//   Parameters:
//     DATA_W        payload bits per frame (1..32)
//     CLKS_PER_BIT  clock cycles each serial bit is held (>=1)
//
//   Ports:
//     CLK         system clock; all logic runs on the rising edge
//     RST         asynchronous reset, active-high
//     DATA_IN     word to send; sampled on accept
//     VALID_IN    DATA_IN valid
//     READY_OUT   block can accept a word this cycle
//     TX_OUT      serial line, idle high
//     BUSY_OUT    frame in progress
//     FRAME_DONE  one-cycle pulse in the last cycle of the stop bit
module ladder_serial_tx #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              VALID_IN,
  output logic              READY_OUT,
  output logic              TX_OUT,
  output logic              BUSY_OUT,
  output logic              FRAME_DONE
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef LADDER_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                bit_end;
`ifdef LADDER_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // Terminal count of the bit-period counter: the current bit ends this cycle.
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef LADDER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef LADDER_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
`ifdef LADDER_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // READY_OUT is high whenever we are here out of reset.
        if (VALID_IN) begin
          state_d = S_START;
          shreg_d = DATA_IN;
`ifdef LADDER_TX_PARITY_EN
          par_d   = ^DATA_IN;
`endif
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef LADDER_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
`ifdef LADDER_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Line level is registered from the next state so it changes on the same
    // edge as the state itself (start bit visible the cycle after accept).
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef LADDER_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign READY_OUT  = (state_q == S_IDLE) && !RST;
  assign BUSY_OUT   = (state_q != S_IDLE);
  assign FRAME_DONE = (state_q == S_STOP) && bit_end;
  assign TX_OUT     = tx_q;

endmodule

// File: tb/tb_ladder_serial_tx.sv
module tb_ladder_serial_tx;

`ifdef LADDER_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int FLEN16 = PBIT ? 76 : 72;
  localparam int FLEN8  = PBIT ? 11 : 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data1;
  logic        valid1;
  logic        ready1, tx1, busy1, done1;
  logic [7:0]  data2;
  logic        valid2;
  logic        ready2, tx2, busy2, done2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ladder_serial_tx #(.DATA_W(16), .CLKS_PER_BIT(4)) dut (
    .CLK(clk), .RST(rst), .DATA_IN(data1), .VALID_IN(valid1),
    .READY_OUT(ready1), .TX_OUT(tx1), .BUSY_OUT(busy1), .FRAME_DONE(done1)
  );

  ladder_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut8 (
    .CLK(clk), .RST(rst), .DATA_IN(data2), .VALID_IN(valid2),
    .READY_OUT(ready2), .TX_OUT(tx2), .BUSY_OUT(busy2), .FRAME_DONE(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at bit position pos (0 = start bit).
  function automatic logic exp_lvl(input logic [31:0] d, input int dw, input int pos);
    logic [31:0] m;
    m = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    if (pos == 0) return 1'b0;
    if (pos <= dw) return d[pos-1];
    if (PBIT == 1 && pos == dw + 1) return ^(d & m);
    return 1'b1;
  endfunction

  // Present a word and wait (bounded) until the block is ready at a negedge.
  task automatic present(input int sel, input logic [31:0] d);
    int n;
    @(negedge clk);
    if (sel == 0) begin data1 = d[15:0]; valid1 = 1'b1; end
    else          begin data2 = d[7:0];  valid2 = 1'b1; end
    n = 0;
    while (((sel == 0) ? ready1 : ready2) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'(n), 32'd0);
  endtask

  // Accept edge, then observe a whole frame plus the following idle cycle.
  // On the first frame cycle the inputs are changed to nd/nv.
  task automatic frame(input int sel, input string tag, input logic [31:0] d,
                       input logic [31:0] nd, input logic nv, input int flen,
                       input logic exp_par, output logic [127:0] wave);
    int dw, cpb, pos, wave_err, busy_err, done_cnt, done_at;
    logic tx, bz, dn, rx_start, rx_stop, rx_par;
    logic [31:0] rx;
    dw  = (sel == 0) ? 16 : 8;
    cpb = (sel == 0) ? 4 : 1;
    wave_err = 0; busy_err = 0; done_cnt = 0; done_at = -1;
    rx = '0; rx_start = 1'bx; rx_stop = 1'bx; rx_par = 1'bx; wave = '0;
    @(posedge clk);
    for (int c = 1; c <= flen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (sel == 0) begin data1 = nd[15:0]; valid1 = nv; end
        else          begin data2 = nd[7:0];  valid2 = nv; end
      end
      tx = (sel == 0) ? tx1 : tx2;
      bz = (sel == 0) ? busy1 : busy2;
      dn = (sel == 0) ? done1 : done2;
      pos = (c - 1) / cpb;
      wave[c-1] = tx;
      if (tx !== exp_lvl(d, dw, pos)) wave_err++;
      if (bz !== 1'b1) busy_err++;
      if (dn === 1'b1) begin done_cnt++; done_at = c; end
      // Receiver model: sample mid-bit.
      if ((c - 1) % cpb == cpb / 2) begin
        if (pos == 0) rx_start = tx;
        else if (pos <= dw) rx[pos-1] = tx;
`ifdef LADDER_TX_PARITY_EN
        else if (pos == dw + 1) rx_par = tx;
`endif
        else rx_stop = tx;
      end
    end
    check({tag, "_wave_err"}, 32'(wave_err), 32'd0);
    check({tag, "_busy_err"}, 32'(busy_err), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(flen));
    check({tag, "_rx_start"}, {31'd0, rx_start}, 32'd0);
    check({tag, "_rx_data"}, rx, d);
    check({tag, "_rx_stop"}, {31'd0, rx_stop}, 32'd1);
`ifdef LADDER_TX_PARITY_EN
    check({tag, "_rx_par"}, {31'd0, rx_par}, {31'd0, exp_par});
`else
    if (exp_par === 1'bz) check({tag, "_par_arg"}, 32'd0, 32'd1);
`endif
    // Mandatory idle cycle after the stop bit.
    @(negedge clk);
    check({tag, "_idle_tx"},    {31'd0, (sel == 0) ? tx1 : tx2},       32'd1);
    check({tag, "_idle_busy"},  {31'd0, (sel == 0) ? busy1 : busy2},   32'd0);
    check({tag, "_idle_ready"}, {31'd0, (sel == 0) ? ready1 : ready2}, 32'd1);
  endtask

  initial begin
    logic [127:0] w;
    int bad;
    rst = 1'b1;
    data1 = 16'h0001; valid1 = 1'b1;
    data2 = 8'h00;    valid2 = 1'b0;

    // Reset held 5 cycles with VALID_IN high.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx1}, 32'd1);
      check("rst_ready", {31'd0, ready1}, 32'd0);
      check("rst_busy", {31'd0, busy1}, 32'd0);
    end
    check("rst_done", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", {31'd0, ready1}, 32'd1);

    // Single frame 0x0001, accepted on the first edge after release.
    frame(0, "f0001", 32'h0001, 32'hBEEF, 1'b0, FLEN16, 1'b1, w);
    check("f0001_start4", {28'd0, w[3:0]}, 32'h0);
    check("f0001_bit0", {28'd0, w[7:4]}, 32'hF);
    check("f0001_low60", {4'd0, w[67:8]}, 32'h0);

    // Parity pattern with an even number of ones.
    present(0, 32'hA5C3);
    frame(0, "fa5c3", 32'hA5C3, 32'h0000, 1'b0, FLEN16, 1'b0, w);

    // Back-to-back with VALID_IN held high.
    present(0, 32'h1234);
    frame(0, "b2b_a", 32'h1234, 32'hFFFF, 1'b1, FLEN16, 1'b1, w);
    frame(0, "b2b_b", 32'hFFFF, 32'h0000, 1'b0, FLEN16, 1'b0, w);

    // Mid-frame reset during bit 7 of 0x00FF.
    present(0, 32'h00FF);
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0;
    for (int c = 2; c <= 33; c++) @(negedge clk);
    check("mid_busy_before", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, tx1}, 32'd1);
    check("mid_rst_busy", {31'd0, busy1}, 32'd0);
    check("mid_rst_ready", {31'd0, ready1}, 32'd0);
    check("mid_rst_done", {31'd0, done1}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_ready", {31'd0, ready1}, 32'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    check("mid_no_residual", 32'(bad), 32'd0);
    present(0, 32'h8001);
    frame(0, "f8001", 32'h8001, 32'h0000, 1'b0, FLEN16, 1'b0, w);

    // One clock per bit, 8-bit payload.
    present(1, 32'h5A);
    frame(1, "f5a", 32'h5A, 32'h00, 1'b0, FLEN8, 1'b0, w);
`ifdef LADDER_TX_PARITY_EN
    check("f5a_pattern", {21'd0, w[10:0]}, 32'b100_1011_0100);
`else
    check("f5a_pattern", {22'd0, w[9:0]}, 32'b10_1011_0100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
